me_param_ctrl: RTL and testbench
================================

// Module: me_param_ctrl
// PURPOSE
//  Command sequencer between the JTAG-driven param1..param3 PIO exports and the motion-estimator core.
//  Decodes host commands, holds the estimator configuration registers, and issues start.
//  Then waits for done, captures the result and reports status.
//  The status is driven onto LEDR bits in the board pin wrapper.
// PARAMETERS
//  TIMEOUT_CYCLES  2**20  busy-cycle limit before abort (used only with ME_TIMEOUT_EN)
//  DEF_STRIDE      640    reset value of cfg_stride
//  DEF_RANGE       16     reset value of cfg_range
//  DEF_BLOCK       8      reset value of cfg_block
// PORTS
//  CYCLONEV_CLK_50  in   1   sole clock, 50 MHz
//  reset            in   1   synchronous, active-high
//  param1           in   32  command: [31] tag (toggle = new command), [3:0] opcode
//  param2           in   32  operand A
//  param3           in   32  operand B
//  me_done          in   1   one-cycle pulse from estimator, run complete
//  me_result        in   32  estimator result, valid with me_done
//  me_start         out  1   one-cycle run pulse
//  me_abort         out  1   one-cycle abort pulse
//  cfg_base         out  32  frame base address
//  cfg_stride       out  16  line stride
//  cfg_range        out  8   search range
//  cfg_block        out  8   block size
//  result_q         out  32  last captured result
//  status           out  10  [0]idle [1]busy [2]done [3]err [4]timeout [5]ack_tag [9:6]last opcode
// BEHAVIOUR
//  Reset values:
//   - me_start=0, me_abort=0, result_q=0, cfg_base=0, other cfg_* = DEF_*.
//   - status=10'h001; internal tag_seen=0; state IDLE.
//   - Host must start issuing commands with tag 0.
//  Command detect: in IDLE, param1[31]!=tag_seen at cycle N -> DECODE at N+1.
//   - DECODE latches param1..3 and sets tag_seen=param1[31].
//  Opcodes, executed at N+2; status[5] = tag and status[9:6] = opcode from then on:
//   - 0 NOP: no effect.
//   - 1 SET_BASE: cfg_base=param2.
//   - 2 SET_GEOM: cfg_stride=param2[15:0], cfg_range=param3[7:0], cfg_block=param3[15:8].
//     If block is not in {4,8,16} or range==0: err=1, all cfg unchanged.
//   - 3 RUN: me_start=1 for exactly cycle N+2; clear done, err and timeout; state BUSY (status[1]).
//   - 4 CLR: clear done, err and timeout.
//   - 5..15: err=1, no other effect.
//  FSM: IDLE -> DECODE -> EXEC -> IDLE, or EXEC -> BUSY -> IDLE.
//  BUSY:
//   - me_done -> result_q=me_result the next cycle, done=1, state IDLE.
//   - New tag toggles are not consumed in BUSY. They stay pending (level compare) and are taken on return to IDLE.
//   - A double toggle while busy is lost.
//  me_done outside BUSY is ignored; result_q is unchanged.
//  cfg_* are never written while BUSY.
//  Reset mid-BUSY: immediate return to reset values, with no me_abort pulse.
// CONFIGURATION
//  ME_TIMEOUT_EN defined:
//   - BUSY counts cycles from entry.
//   - At TIMEOUT_CYCLES without me_done: me_abort=1 for one cycle, timeout=1, err=1, state IDLE.
//   - If me_done arrives in the same cycle, me_done wins.
//  ME_TIMEOUT_EN undefined:
//   - BUSY waits indefinitely; me_abort is tied 0 and status[4] stays 0.
// STRUCTURE
//  Package me_ctrl_pkg holds:
//   - opcode enum: NOP, SET_BASE, SET_GEOM, RUN, CLR.
//   - state enum: IDLE, DECODE, EXEC, BUSY.
//   - status bit index constants and legal block-size constants.
//  Sub-module me_busy_timer: load/enable counter with an expired flag.
//   - Instantiated only under ME_TIMEOUT_EN.
// TESTING
//  1 Reset, then hold param1=0 -> status=10'h001, cfg_stride=640, cfg_range=16, cfg_block=8, no me_start.
//  2 param2=32'h0001_0000, param1=32'h8000_0001 -> cfg_base=32'h0001_0000 at N+2, status[5]=1, status[9:6]=1.
//  3 param3=32'h0000_0C20, param1 toggled with op 2 -> err=1, cfg_block remains 8 (12 is illegal).
//  4 RUN toggle -> me_start high only at N+2.
//    - me_done with me_result=32'h00AB_0012 after 50 cycles -> result_q captured, status[2]=1, state IDLE.
//  5 Toggle SET_BASE during BUSY -> cfg_base unchanged until after me_done, then applied 2 cycles after IDLE.
//  6 ME_TIMEOUT_EN with TIMEOUT_CYCLES=100, RUN and no me_done -> me_abort pulse at cycle 100 of BUSY, status[4]=1 and [3]=1.

Source files
------------

// File: rtl/me_ctrl_pkg.sv
// Shared types and constants for the motion-estimator parameter controller.
// Opcode and state encodings, status bit positions and legal block sizes.
package me_ctrl_pkg;

    typedef enum logic [3:0] {
        OpNop     = 4'd0,
        OpSetBase = 4'd1,
        OpSetGeom = 4'd2,
        OpRun     = 4'd3,
        OpClr     = 4'd4
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExec,
        StBusy
    } state_e;

    localparam int unsigned STATUS_W     = 10;
    localparam int unsigned STAT_IDLE    = 0;
    localparam int unsigned STAT_BUSY    = 1;
    localparam int unsigned STAT_DONE    = 2;
    localparam int unsigned STAT_ERR     = 3;
    localparam int unsigned STAT_TIMEOUT = 4;
    localparam int unsigned STAT_ACK_TAG = 5;
    localparam int unsigned STAT_OP_LSB  = 6;

    localparam logic [7:0] BLOCK_4  = 8'd4;
    localparam logic [7:0] BLOCK_8  = 8'd8;
    localparam logic [7:0] BLOCK_16 = 8'd16;

    function automatic logic geom_legal(input logic [7:0] rng, input logic [7:0] blk);
        return (rng != 8'd0) && ((blk == BLOCK_4) || (blk == BLOCK_8) || (blk == BLOCK_16));
    endfunction

endpackage

// File: rtl/me_busy_timer.sv
// Busy-cycle counter: cleared by load, advances while enabled, flags the last allowed cycle.
// Only instantiated when ME_TIMEOUT_EN is defined.
module me_busy_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + W'(1);
        end
    end

    // count_q holds (busy cycle - 1), so this asserts during the LIMIT-th busy cycle
    assign expired = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/me_param_ctrl.sv
// Host command sequencer for the motion estimator: decodes tagged commands, holds config, runs.
// Optional busy timeout with abort is enabled by defining ME_TIMEOUT_EN.
module me_param_ctrl
    import me_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2**20,
    parameter logic [15:0] DEF_STRIDE     = 16'd640,
    parameter logic [7:0]  DEF_RANGE      = 8'd16,
    parameter logic [7:0]  DEF_BLOCK      = 8'd8
) (
    input  logic                CYCLONEV_CLK_50,
    input  logic                reset,
    input  logic [31:0]         param1,
    input  logic [31:0]         param2,
    input  logic [31:0]         param3,
    input  logic                me_done,
    input  logic [31:0]         me_result,
    output logic                me_start,
    output logic                me_abort,
    output logic [31:0]         cfg_base,
    output logic [15:0]         cfg_stride,
    output logic [7:0]          cfg_range,
    output logic [7:0]          cfg_block,
    output logic [31:0]         result_q,
    output logic [STATUS_W-1:0] status
);

    state_e     state_q;
    logic       tag_seen_q;
    logic       ack_tag_q;
    logic [3:0] last_op_q;
    logic       done_q;
    logic       err_q;
    logic       timeout_q;
    logic       timer_expired;

    logic unused_param;
    assign unused_param = ^{param1[30:4], param3[31:16]};

`ifdef ME_TIMEOUT_EN
    me_busy_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_busy_timer (
        .clk     (CYCLONEV_CLK_50),
        .reset   (reset),
        .load    (state_q == StExec),
        .enable  (state_q == StBusy),
        .expired (timer_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timer_expired  = 1'b0;
    assign me_abort       = 1'b0;
`endif

    always_ff @(posedge CYCLONEV_CLK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            tag_seen_q <= 1'b0;
            ack_tag_q  <= 1'b0;
            last_op_q  <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            me_start   <= 1'b0;
            result_q   <= '0;
            cfg_base   <= '0;
            cfg_stride <= DEF_STRIDE;
            cfg_range  <= DEF_RANGE;
            cfg_block  <= DEF_BLOCK;
`ifdef ME_TIMEOUT_EN
            me_abort   <= 1'b0;
`endif
        end else begin
            me_start <= 1'b0;
`ifdef ME_TIMEOUT_EN
            me_abort <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    // Level compare: a toggle made while busy is still seen here afterwards
                    if (param1[31] != tag_seen_q) begin
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    // Operands are applied at the latch edge so effects are visible during EXEC
                    tag_seen_q <= param1[31];
                    ack_tag_q  <= param1[31];
                    last_op_q  <= param1[3:0];
                    state_q    <= StExec;
                    case (opcode_e'(param1[3:0]))
                        OpNop: ;
                        OpSetBase: cfg_base <= param2;
                        OpSetGeom: begin
                            if (geom_legal(param3[7:0], param3[15:8])) begin
                                cfg_stride <= param2[15:0];
                                cfg_range  <= param3[7:0];
                                cfg_block  <= param3[15:8];
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                        OpRun: begin
                            me_start  <= 1'b1;
                            done_q    <= 1'b0;
                            err_q     <= 1'b0;
                            timeout_q <= 1'b0;
                        end
                        OpClr: begin
                            done_q    <= 1'b0;
                            err_q     <= 1'b0;
                            timeout_q <= 1'b0;
                        end
                        default: err_q <= 1'b1;
                    endcase
                end
                StExec: begin
                    state_q <= (opcode_e'(last_op_q) == OpRun) ? StBusy : StIdle;
                end
                StBusy: begin
                    if (me_done) begin
                        result_q <= me_result;
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else if (timer_expired) begin
`ifdef ME_TIMEOUT_EN
                        me_abort <= 1'b1;
`endif
                        timeout_q <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        status                     = '0;
        status[STAT_IDLE]          = (state_q == StIdle);
        status[STAT_BUSY]          = (state_q == StBusy);
        status[STAT_DONE]          = done_q;
        status[STAT_ERR]           = err_q;
        status[STAT_TIMEOUT]       = timeout_q;
        status[STAT_ACK_TAG]       = ack_tag_q;
        status[STAT_OP_LSB +: 4]   = last_op_q;
    end

endmodule

// File: tb/tb_me_param_ctrl.sv
// Self-checking bench for me_param_ctrl: directed scenarios plus randomized command streams
// checked against a command-level behavioural model.
module tb_me_param_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] param1, param2, param3;
    logic        me_done;
    logic [31:0] me_result;
    logic        me_start, me_abort;
    logic [31:0] cfg_base;
    logic [15:0] cfg_stride;
    logic [7:0]  cfg_range, cfg_block;
    logic [31:0] result_q;
    logic [9:0]  status;

    int n_checks = 0;
    int n_errors = 0;

    // Command-level model state
    logic [31:0] m_base, m_result;
    logic [15:0] m_stride;
    logic [7:0]  m_range, m_block;
    logic [3:0]  m_op;
    bit          m_tag, m_done, m_err, m_to;
    bit          host_tag;

    me_param_ctrl #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CYCLONEV_CLK_50 (clk),
        .reset           (reset),
        .param1          (param1),
        .param2          (param2),
        .param3          (param3),
        .me_done         (me_done),
        .me_result       (me_result),
        .me_start        (me_start),
        .me_abort        (me_abort),
        .cfg_base        (cfg_base),
        .cfg_stride      (cfg_stride),
        .cfg_range       (cfg_range),
        .cfg_block       (cfg_block),
        .result_q        (result_q),
        .status          (status)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input bit idle);
        return {22'd0, m_op, m_tag, m_to, m_err, m_done, busy, idle};
    endfunction

    task automatic model_reset();
        m_base = '0; m_stride = 16'd640; m_range = 8'd16; m_block = 8'd8;
        m_result = '0; m_op = '0; m_tag = 0; m_done = 0; m_err = 0; m_to = 0;
        host_tag = 0;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output bit is_run);
        m_tag = host_tag;
        m_op  = op;
        is_run = 0;
        case (op)
            4'd0: ;
            4'd1: m_base = a;
            4'd2: begin
                if (b[7:0] != 0 && (b[15:8] == 4 || b[15:8] == 8 || b[15:8] == 16)) begin
                    m_stride = a[15:0]; m_range = b[7:0]; m_block = b[15:8];
                end else begin
                    m_err = 1;
                end
            end
            4'd3: begin m_done = 0; m_err = 0; m_to = 0; is_run = 1; end
            4'd4: begin m_done = 0; m_err = 0; m_to = 0; end
            default: m_err = 1;
        endcase
    endtask

    task automatic check_cfg();
        check_eq("cfg_base", cfg_base, m_base);
        check_eq("cfg_stride", 32'(cfg_stride), 32'(m_stride));
        check_eq("cfg_range", 32'(cfg_range), 32'(m_range));
        check_eq("cfg_block", 32'(cfg_block), 32'(m_block));
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [26:0] junk;
        junk     = 27'($urandom);
        host_tag = ~host_tag;
        param1   = {host_tag, junk, op};
        param2   = a;
        param3   = b;
    endtask

    // Called at the negedge of the IDLE cycle in which the toggle is visible
    task automatic expect_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output bit is_run);
        @(negedge clk);
        check_eq("dec_start", 32'(me_start), 32'd0);
        check_eq("dec_status", 32'(status), exp_status(0, 0));
        model_apply(op, a, b, is_run);
        @(negedge clk);
        check_eq("exec_start", 32'(me_start), 32'(is_run));
        check_cfg();
        check_eq("exec_status", 32'(status), exp_status(0, 0));
        @(negedge clk);
        check_eq("post_start", 32'(me_start), 32'd0);
        check_eq("post_status", 32'(status), exp_status(is_run, !is_run));
    endtask

    function automatic logic [31:0] rand_geom();
        logic [7:0] blk;
        case ($urandom_range(0, 2))
            0: blk = 8'd4;
            1: blk = 8'd8;
            default: blk = 8'd16;
        endcase
        if ($urandom_range(0, 1) == 0) return {16'($urandom), blk, 8'($urandom_range(1, 255))};
        return $urandom;
    endfunction

    function automatic logic [3:0] rand_nonrun_op();
        case ($urandom_range(0, 4))
            0: return 4'd0;
            1: return 4'd1;
            2: return 4'd2;
            3: return 4'd4;
            default: return 4'($urandom_range(5, 15));
        endcase
    endfunction

    // Called at the negedge of BUSY cycle 1; done is raised so it is seen in BUSY cycle lat
    task automatic finish_run(input int lat, input logic [31:0] res, input bit pend,
                              input logic [3:0] p_op, input logic [31:0] p_a,
                              input logic [31:0] p_b);
        bit r;
        if (pend) send_cmd(p_op, p_a, p_b);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            check_eq("busy_start", 32'(me_start), 32'd0);
        end
        check_eq("busy_status", 32'(status), exp_status(1, 0));
        check_eq("busy_abort", 32'(me_abort), 32'd0);
        me_done   = 1'b1;
        me_result = res;
        @(negedge clk);
        me_done   = 1'b0;
        me_result = $urandom;
        m_result  = res;
        m_done    = 1;
        check_eq("result_q", result_q, m_result);
        check_eq("done_status", 32'(status), exp_status(0, 1));
        check_eq("busy_base_hold", cfg_base, m_base);
        if (pend) expect_cmd(p_op, p_a, p_b, r);
    endtask

    task automatic stray_done();
        me_done   = 1'b1;
        me_result = $urandom;
        @(negedge clk);
        me_done = 1'b0;
        @(negedge clk);
        check_eq("stray_result", result_q, m_result);
        check_eq("stray_status", 32'(status), exp_status(0, 1));
    endtask

    initial begin
        bit          r;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; param1 = '0; param2 = '0; param3 = '0;
        me_done = 1'b0; me_result = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state with param1 held at 0
        check_eq("rst_status", 32'(status), 32'h001);
        check_eq("rst_stride", 32'(cfg_stride), 32'd640);
        check_eq("rst_range", 32'(cfg_range), 32'd16);
        check_eq("rst_block", 32'(cfg_block), 32'd8);
        check_eq("rst_base", cfg_base, 32'd0);
        check_eq("rst_start", 32'(me_start), 32'd0);
        check_eq("rst_result", result_q, 32'd0);
        check_eq("rst_abort", 32'(me_abort), 32'd0);

        // SET_BASE
        send_cmd(4'd1, 32'h0001_0000, 32'd0);
        expect_cmd(4'd1, 32'h0001_0000, 32'd0, r);
        check_eq("t2_base", cfg_base, 32'h0001_0000);
        check_eq("t2_tag_op", 32'(status[9:5]), 32'h03);

        // SET_GEOM with illegal block 12
        a = $urandom;
        send_cmd(4'd2, a, 32'h0000_0C20);
        expect_cmd(4'd2, a, 32'h0000_0C20, r);
        check_eq("t3_block", 32'(cfg_block), 32'd8);
        check_eq("t3_err", 32'(status[3]), 32'd1);

        // RUN with done after 50 cycles
        send_cmd(4'd3, 32'd0, 32'd0);
        expect_cmd(4'd3, 32'd0, 32'd0, r);
        finish_run(50, 32'h00AB_0012, 1'b0, 4'd0, 32'd0, 32'd0);
        check_eq("t4_result", result_q, 32'h00AB_0012);

        // SET_BASE toggled while busy is held until IDLE
        send_cmd(4'd3, 32'd0, 32'd0);
        expect_cmd(4'd3, 32'd0, 32'd0, r);
        finish_run(20, 32'h1234_5678, 1'b1, 4'd1, 32'hCAFE_0040, 32'd0);
        check_eq("t5_base", cfg_base, 32'hCAFE_0040);

        stray_done();

        // Randomized command stream
        for (int it = 0; it < 40; it++) begin
            op = ($urandom_range(0, 2) == 0) ? 4'd3 : rand_nonrun_op();
            a  = $urandom;
            b  = rand_geom();
            send_cmd(op, a, b);
            expect_cmd(op, a, b, r);
            if (r) begin
                finish_run($urandom_range(1, 60), $urandom, $urandom_range(0, 2) == 0,
                           rand_nonrun_op(), $urandom, rand_geom());
            end
            if ($urandom_range(0, 4) == 0) stray_done();
        end

`ifdef ME_TIMEOUT_EN
        // RUN with no done: abort after 100 busy cycles
        send_cmd(4'd3, 32'd0, 32'd0);
        expect_cmd(4'd3, 32'd0, 32'd0, r);
        for (int i = 2; i <= 100; i++) begin
            @(negedge clk);
            check_eq("to_wait_abort", 32'(me_abort), 32'd0);
        end
        check_eq("to_busy", 32'(status), exp_status(1, 0));
        @(negedge clk);
        m_to = 1; m_err = 1;
        check_eq("to_abort", 32'(me_abort), 32'd1);
        check_eq("to_status", 32'(status), exp_status(0, 1));
        @(negedge clk);
        check_eq("to_abort_end", 32'(me_abort), 32'd0);
`endif

        // Reset while busy
        send_cmd(4'd3, 32'd0, 32'd0);
        expect_cmd(4'd3, 32'd0, 32'd0, r);
        repeat (5) @(negedge clk);
        reset  = 1'b1;
        param1 = '0;
        @(negedge clk);
        check_eq("mid_rst_abort", 32'(me_abort), 32'd0);
        check_eq("mid_rst_start", 32'(me_start), 32'd0);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("mid_rst_status", 32'(status), 32'h001);
        check_cfg();
        check_eq("mid_rst_result", result_q, 32'd0);

        // Tag restarts from 0 after reset
        a = $urandom;
        send_cmd(4'd1, a, 32'd0);
        expect_cmd(4'd1, a, 32'd0, r);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
